// File: rtl/invtran_pkg.sv
// -----------------------------------------------------------------------------
// invtran_pkg
// Shared types and helpers for the inverse-transform arbiter slice.
//   DEF_BIT_LENGTH : default MSB index of a signed coefficient/residual
//   coef_t / blk_t : one coefficient / one 4x4 block of 16 coefficients
//   src_t          : requester identity (0 = luma, 1 = chroma)
//   tag_t          : {valid, src} carried alongside a block inside the core
//   rr_grant       : two-way round-robin pick returning a one-hot grant
// -----------------------------------------------------------------------------
package invtran_pkg;

  localparam int DEF_BIT_LENGTH = 15;

  typedef logic signed [DEF_BIT_LENGTH:0] coef_t;
  typedef coef_t [15:0]                   blk_t;

  typedef logic src_t;
  localparam src_t SRC_LUMA   = 1'b0;
  localparam src_t SRC_CHROMA = 1'b1;

  typedef struct packed {
    logic valid;
    src_t src;
  } tag_t;

  // With both requesters eligible the one that did not win last time goes.
  function automatic logic [1:0] rr_grant(input logic [1:0] elig, input logic last);
    logic [1:0] gnt;
    gnt = 2'b00;
    case (elig)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    return gnt;
  endfunction

endpackage

// File: rtl/invtran_resp_fifo.sv
// -----------------------------------------------------------------------------
// invtran_resp_fifo
// First-word-fall-through response FIFO; the head entry is visible on data_o
// whenever valid_o is high and advances on the edge after valid_o & rd_en_i.
// Ports:
//   clk, reset     : clock, asynchronous active-low reset (empties the FIFO)
//   wr_en_i/data_i : push one block
//   rd_en_i        : pop request (ignored when empty)
//   valid_o/data_o : non-empty flag and head block (zero when empty)
//   count_o        : current occupancy
// -----------------------------------------------------------------------------
module invtran_resp_fifo
  import invtran_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = $bits(blk_t),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          rd_en_i,
  output logic          valid_o,
  output logic [W-1:0]  data_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_s, pop_s, full_s;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Next-state for pointers and occupancy; push and pop in one cycle net out.
  always_comb begin
    full_s   = (count_q == CW'(DEPTH));
    pop_s    = rd_en_i && (count_q != {CW{1'b0}});
    push_s   = wr_en_i && (!full_s || pop_s);
    wr_ptr_d = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_s  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; cleared on reset so no stale residual survives it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {W{1'b0}};
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign valid_o = (count_q != {CW{1'b0}});
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : {W{1'b0}};
  assign count_o = count_q;

endmodule

// File: rtl/invtran_arbiter.sv
// -----------------------------------------------------------------------------
// invtran_arbiter
// Shares one fixed-latency pipelined 4x4 inverse-transform core between a luma
// requester (0) and a chroma requester (1). Round-robin issue of at most one
// block per cycle, a {valid, src} tag pipeline that mirrors the core latency,
// and per-requester response FIFOs protected by credits so the non-stalling
// core can never overrun them.
// Ports:
//   clk, reset               : clock, asynchronous active-low reset
//   enable                   : gates new grants only
//   req_valid / req_ready    : per-requester handshake (ready is combinational)
//   req0_coef / req1_coef    : input coefficient blocks
//   core_valid / core_coef   : registered issue to the core
//   core_res                 : core output, CORE_LATENCY cycles after core_valid
//   resp_valid / resp_ready  : per-requester FIFO handshake
//   resp0_data / resp1_data  : FIFO heads
// -----------------------------------------------------------------------------
module invtran_arbiter
  import invtran_pkg::*;
#(
  parameter int BIT_LENGTH   = DEF_BIT_LENGTH,
  parameter int CORE_LATENCY = 2,
  parameter int RESP_DEPTH   = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [1:0]                      req_valid,
  output logic [1:0]                      req_ready,
  input  logic signed [15:0][BIT_LENGTH:0] req0_coef,
  input  logic signed [15:0][BIT_LENGTH:0] req1_coef,
  output logic                            core_valid,
  output logic signed [15:0][BIT_LENGTH:0] core_coef,
  input  logic signed [15:0][BIT_LENGTH:0] core_res,
  output logic [1:0]                      resp_valid,
  input  logic [1:0]                      resp_ready,
  output logic signed [15:0][BIT_LENGTH:0] resp0_data,
  output logic signed [15:0][BIT_LENGTH:0] resp1_data
);

  localparam int W  = 16 * (BIT_LENGTH + 1);
  localparam int CW = $clog2(RESP_DEPTH + 1);

  logic                             core_valid_q, core_valid_d;
  logic signed [15:0][BIT_LENGTH:0] core_coef_q, core_coef_d;
  src_t                             core_src_q, core_src_d;
  logic                             last_q, last_d;
  tag_t                             tag_q [CORE_LATENCY];
  tag_t                             tail_s;

  logic [1:0][CW-1:0] occ_s;
  logic [1:0][CW-1:0] infl_s;
  logic [1:0][CW-1:0] credit_s;
  logic [1:0]         elig_s;
  logic [1:0]         gnt_s;
  logic               accept_s;
  logic [1:0]         fifo_wr_s;

  // Credits: a block counts against its requester from the issue register
  // through every tag stage until it lands in the FIFO. All terms are
  // registered, so a pop only frees credit on the following cycle.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      infl_s[i] = CW'(core_valid_q && (core_src_q == src_t'(i)));
      for (int s = 0; s < CORE_LATENCY; s++) begin
        infl_s[i] = infl_s[i] + CW'(tag_q[s].valid && (tag_q[s].src == src_t'(i)));
      end
      credit_s[i] = CW'(RESP_DEPTH) - occ_s[i] - infl_s[i];
      elig_s[i]   = enable && req_valid[i] && (credit_s[i] != {CW{1'b0}});
    end
  end

  // Grant selection; held off while reset is asserted.
  always_comb begin
    gnt_s    = rr_grant(elig_s, last_q);
    accept_s = |gnt_s;
    if (reset) begin
      req_ready = gnt_s;
    end else begin
      req_ready = 2'b00;
    end
  end

  // Issue-stage next state; core_coef holds its last block when idle.
  always_comb begin
    core_valid_d = accept_s;
    core_coef_d  = core_coef_q;
    core_src_d   = core_src_q;
    last_d       = last_q;
    if (accept_s) begin
      core_coef_d = gnt_s[1] ? req1_coef : req0_coef;
      core_src_d  = src_t'(gnt_s[1]);
      last_d      = gnt_s[1];
    end else begin
      core_coef_d = core_coef_q;
    end
  end

  // Issue register and round-robin pointer (requester 0 wins the first tie).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_valid_q <= 1'b0;
      core_coef_q  <= '{default: '0};
      core_src_q   <= SRC_LUMA;
      last_q       <= 1'b1;
    end else begin
      core_valid_q <= core_valid_d;
      core_coef_q  <= core_coef_d;
      core_src_q   <= core_src_d;
      last_q       <= last_d;
    end
  end

  // Tag pipeline matching the core latency; reset discards in-flight blocks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < CORE_LATENCY; s++) begin
        tag_q[s] <= '{valid: 1'b0, src: SRC_LUMA};
      end
    end else begin
      tag_q[0] <= '{valid: core_valid_q, src: core_src_q};
      for (int s = 1; s < CORE_LATENCY; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  assign tail_s       = tag_q[CORE_LATENCY-1];
  assign fifo_wr_s[0] = tail_s.valid && (tail_s.src == SRC_LUMA);
  assign fifo_wr_s[1] = tail_s.valid && (tail_s.src == SRC_CHROMA);
  assign core_valid   = core_valid_q;
  assign core_coef    = core_coef_q;

  invtran_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .W     (W),
    .CW    (CW)
  ) u_fifo0 (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (fifo_wr_s[0]),
    .wr_data_i (core_res),
    .rd_en_i   (resp_ready[0]),
    .valid_o   (resp_valid[0]),
    .data_o    (resp0_data),
    .count_o   (occ_s[0])
  );

  invtran_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .W     (W),
    .CW    (CW)
  ) u_fifo1 (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (fifo_wr_s[1]),
    .wr_data_i (core_res),
    .rd_en_i   (resp_ready[1]),
    .valid_o   (resp_valid[1]),
    .data_o    (resp1_data),
    .count_o   (occ_s[1])
  );

endmodule

// File: tb/tb_invtran_arbiter.sv
module tb_invtran_arbiter;

  localparam int BL    = 15;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  typedef logic [15:0][BL:0] tblk_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [1:0] req_valid, req_ready, resp_valid, resp_ready;
  tblk_t      req0_coef, req1_coef, core_coef, core_res, resp0_data, resp1_data;
  logic       core_valid;

  int checks = 0;
  int errors = 0;

  tblk_t q0[$];
  tblk_t q1[$];

  always #5 clk = ~clk;

  invtran_arbiter #(
    .BIT_LENGTH   (BL),
    .CORE_LATENCY (LAT),
    .RESP_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req0_coef  (req0_coef),
    .req1_coef  (req1_coef),
    .core_valid (core_valid),
    .core_coef  (core_coef),
    .core_res   (core_res),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp0_data (resp0_data),
    .resp1_data (resp1_data)
  );

  // Core model: reverses coefficient order and flips a bit pattern, LAT cycles.
  function automatic tblk_t core_fn(input tblk_t b);
    tblk_t r;
    for (int i = 0; i < 16; i++) r[i] = b[15-i] ^ 16'h5A5A;
    return r;
  endfunction

  function automatic tblk_t mk_blk(input int base);
    tblk_t r;
    for (int i = 0; i < 16; i++) r[i] = 16'(base + i);
    return r;
  endfunction

  tblk_t core_pipe [LAT];
  always @(posedge clk) begin
    core_pipe[0] <= core_coef;
    for (int s = 1; s < LAT; s++) core_pipe[s] <= core_pipe[s-1];
  end
  assign core_res = core_fn(core_pipe[LAT-1]);

  task automatic drive_pt();
    @(posedge clk);
    #1;
  endtask

  task automatic samp_pt();
    @(negedge clk);
  endtask

  task automatic set_idle();
    req_valid  = 2'b00;
    resp_ready = 2'b00;
    enable     = 1'b1;
    req0_coef  = mk_blk(0);
    req1_coef  = mk_blk(0);
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b0;
    repeat (2) drive_pt();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    set_idle();
    reset     = 1'b0;
    req_valid = 2'b11;
    samp_pt();
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", req_ready); end
    checks++; if (core_valid !== 1'b0) begin errors++; $display("FAIL reset_core_valid: got %b want 0", core_valid); end
    checks++; if (core_coef !== '0) begin errors++; $display("FAIL reset_core_coef: got %h want 0", core_coef); end
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL reset_resp_valid: got %b want 00", resp_valid); end
    checks++; if (resp0_data !== '0 || resp1_data !== '0) begin errors++; $display("FAIL reset_resp_data: got %h / %h want 0", resp0_data, resp1_data); end
    drive_pt();
    reset     = 1'b1;
    req_valid = 2'b00;
  endtask

  task automatic test_single();
    for (int t = 0; t <= 6; t++) begin
      req_valid  = (t == 0) ? 2'b01 : 2'b00;
      req0_coef  = mk_blk(0);
      resp_ready = (t == 5) ? 2'b01 : 2'b00;
      samp_pt();
      if (t == 0) begin
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b want 01", req_ready); end
      end
      if (t == 1) begin
        checks++; if (core_valid !== 1'b1 || core_coef !== mk_blk(0)) begin errors++; $display("FAIL single_issue: got %b %h want 1 %h", core_valid, core_coef, mk_blk(0)); end
      end
      if (t == 2) begin
        checks++; if (core_valid !== 1'b0) begin errors++; $display("FAIL single_issue_end: got %b want 0", core_valid); end
      end
      if (t >= 1 && t <= 3) begin
        checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL single_early_resp t=%0d: got %b want 00", t, resp_valid); end
      end
      if (t == 4) begin
        checks++; if (resp_valid !== 2'b01) begin errors++; $display("FAIL single_resp_valid: got %b want 01", resp_valid); end
        checks++; if (resp0_data !== core_fn(mk_blk(0))) begin errors++; $display("FAIL single_resp_data: got %h want %h", resp0_data, core_fn(mk_blk(0))); end
      end
      if (t == 6) begin
        checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL single_after_pop: got %b want 00", resp_valid); end
      end
      drive_pt();
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp_rv;
    do_reset();
    for (int t = 0; t <= 10; t++) begin
      req_valid  = (t < 6) ? 2'b11 : 2'b00;
      req0_coef  = mk_blk(100 + t);
      req1_coef  = mk_blk(200 + t);
      resp_ready = 2'b11;
      samp_pt();
      if (t < 6) begin
        checks++; if (req_ready !== ((t % 2 == 0) ? 2'b01 : 2'b10)) begin errors++; $display("FAIL contention_grant t=%0d: got %b", t, req_ready); end
      end
      exp_rv = (t >= 4 && t <= 9) ? ((t % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      checks++; if (resp_valid !== exp_rv) begin errors++; $display("FAIL contention_resp_valid t=%0d: got %b want %b", t, resp_valid, exp_rv); end
      if (exp_rv == 2'b01) begin
        checks++; if (resp0_data !== core_fn(mk_blk(100 + t - 4))) begin errors++; $display("FAIL contention_resp0 t=%0d: got %h", t, resp0_data); end
      end
      if (exp_rv == 2'b10) begin
        checks++; if (resp1_data !== core_fn(mk_blk(200 + t - 4))) begin errors++; $display("FAIL contention_resp1 t=%0d: got %h", t, resp1_data); end
      end
      drive_pt();
    end
  endtask

  task automatic test_backpressure();
    int grants;
    logic [1:0] exp_rdy;
    grants = 0;
    do_reset();
    for (int t = 0; t <= 12; t++) begin
      req_valid  = 2'b10;
      req1_coef  = mk_blk(300 + t);
      resp_ready = (t == 10) ? 2'b10 : 2'b00;
      samp_pt();
      exp_rdy = (t <= 3 || t == 11) ? 2'b10 : 2'b00;
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL backpressure_ready t=%0d: got %b want %b", t, req_ready, exp_rdy); end
      if (req_ready[1]) grants++;
      if (t == 9) begin
        checks++; if (resp_valid !== 2'b10) begin errors++; $display("FAIL backpressure_full_valid: got %b want 10", resp_valid); end
      end
      if (t == 10) begin
        checks++; if (resp1_data !== core_fn(mk_blk(300))) begin errors++; $display("FAIL backpressure_head0: got %h", resp1_data); end
      end
      if (t == 11) begin
        checks++; if (resp1_data !== core_fn(mk_blk(301))) begin errors++; $display("FAIL backpressure_head1: got %h", resp1_data); end
      end
      drive_pt();
    end
    checks++; if (grants != DEPTH + 1) begin errors++; $display("FAIL backpressure_grants: got %0d want %0d", grants, DEPTH + 1); end
  endtask

  task automatic test_enable_low();
    logic [1:0] exp_rdy, exp_rv;
    do_reset();
    for (int t = 0; t <= 7; t++) begin
      enable     = (t < 2);
      req_valid  = 2'b11;
      req0_coef  = mk_blk(400 + t);
      req1_coef  = mk_blk(500 + t);
      resp_ready = 2'b11;
      samp_pt();
      exp_rdy = (t == 0) ? 2'b01 : ((t == 1) ? 2'b10 : 2'b00);
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL enable_ready t=%0d: got %b want %b", t, req_ready, exp_rdy); end
      exp_rv = (t == 4) ? 2'b01 : ((t == 5) ? 2'b10 : 2'b00);
      checks++; if (resp_valid !== exp_rv) begin errors++; $display("FAIL enable_resp_valid t=%0d: got %b want %b", t, resp_valid, exp_rv); end
      if (t == 4) begin
        checks++; if (resp0_data !== core_fn(mk_blk(400))) begin errors++; $display("FAIL enable_resp0: got %h", resp0_data); end
      end
      if (t == 5) begin
        checks++; if (resp1_data !== core_fn(mk_blk(501))) begin errors++; $display("FAIL enable_resp1: got %h", resp1_data); end
      end
      drive_pt();
    end
    enable = 1'b1;
  endtask

  task automatic test_reset_midflight();
    do_reset();
    req_valid = 2'b01; req0_coef = mk_blk(600);
    samp_pt();
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL midreset_g0: got %b want 01", req_ready); end
    drive_pt();
    req_valid = 2'b10; req1_coef = mk_blk(701);
    samp_pt();
    checks++; if (req_ready !== 2'b10 || core_valid !== 1'b1) begin errors++; $display("FAIL midreset_g1: got %b %b want 10 1", req_ready, core_valid); end
    drive_pt();
    reset     = 1'b0;
    req_valid = 2'b11;
    #1;
    checks++; if (core_valid !== 1'b0 || core_coef !== '0) begin errors++; $display("FAIL midreset_core: got %b %h want 0 0", core_valid, core_coef); end
    checks++; if (req_ready !== 2'b00 || resp_valid !== 2'b00) begin errors++; $display("FAIL midreset_hs: got %b %b want 00 00", req_ready, resp_valid); end
    checks++; if (resp0_data !== '0 || resp1_data !== '0) begin errors++; $display("FAIL midreset_data: got %h %h want 0", resp0_data, resp1_data); end
    repeat (2) drive_pt();
    reset     = 1'b1;
    req_valid = 2'b00;
    for (int t = 0; t < 8; t++) begin
      samp_pt();
      checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL midreset_ghost t=%0d: got %b want 00", t, resp_valid); end
      drive_pt();
    end
    req_valid = 2'b11;
    samp_pt();
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL midreset_first_tie: got %b want 01", req_ready); end
    drive_pt();
    req_valid = 2'b00;
  endtask

  task automatic test_random();
    tblk_t exp_b;
    do_reset();
    q0.delete();
    q1.delete();
    for (int cyc = 0; cyc < 10012; cyc++) begin
      if (cyc < 10000) begin
        req_valid  = 2'($urandom_range(0, 3));
        resp_ready = 2'($urandom_range(0, 3));
        enable     = ($urandom_range(0, 7) != 0);
        for (int i = 0; i < 16; i++) begin
          req0_coef[i] = 16'($urandom);
          req1_coef[i] = 16'($urandom);
        end
      end else begin
        req_valid  = 2'b00;
        resp_ready = 2'b11;
        enable     = 1'b1;
      end
      samp_pt();
      checks++; if ((req_ready & ~req_valid) != 2'b00 || req_ready == 2'b11) begin errors++; $display("FAIL random_grant cyc=%0d: ready %b valid %b", cyc, req_ready, req_valid); end
      checks++; if ((dut.fifo_wr_s[0] && dut.occ_s[0] == 3'(DEPTH)) || (dut.fifo_wr_s[1] && dut.occ_s[1] == 3'(DEPTH))) begin errors++; $display("FAIL random_full_write cyc=%0d: occ %0d %0d", cyc, dut.occ_s[0], dut.occ_s[1]); end
      if (req_valid[0] && req_ready[0]) q0.push_back(core_fn(req0_coef));
      if (req_valid[1] && req_ready[1]) q1.push_back(core_fn(req1_coef));
      if (resp_valid[0] && resp_ready[0]) begin
        exp_b = (q0.size() > 0) ? q0.pop_front() : '0;
        checks++; if (resp0_data !== exp_b) begin errors++; $display("FAIL random_resp0 cyc=%0d: got %h want %h", cyc, resp0_data, exp_b); end
      end
      if (resp_valid[1] && resp_ready[1]) begin
        exp_b = (q1.size() > 0) ? q1.pop_front() : '0;
        checks++; if (resp1_data !== exp_b) begin errors++; $display("FAIL random_resp1 cyc=%0d: got %h want %h", cyc, resp1_data, exp_b); end
      end
      drive_pt();
    end
    checks++; if (q0.size() != 0 || q1.size() != 0) begin errors++; $display("FAIL random_drain: left %0d %0d want 0 0", q0.size(), q1.size()); end
    checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL random_drain_valid: got %b want 00", resp_valid); end
  endtask

  initial begin
    set_idle();
    reset = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_enable_low();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
